// File: rtl/pong_btn_debounce.sv
// Four-channel push-button debouncer for the pong animation stage.
// Synchronises raw pins, filters bounce, emits levels and press ticks.
module pong_btn_debounce #(
  parameter int N_BTN          = 4,
  parameter int DB_CYCLES      = 500000,
  parameter int CNT_W          = 20,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btnm,
  output logic [N_BTN-1:0] btn_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [N_BTN-1:0] INV =
    BTN_ACTIVE_LOW ? {N_BTN{1'b1}} : {N_BTN{1'b0}};
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] p;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] s;

  assign p = btn_raw ^ INV;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= p;
      s     <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st   <= ZERO;
        cnt  <= '0;
        tick <= 1'b0;
      end else begin
        tick <= 1'b0;
        unique case (st)
          ZERO: begin
            if (s[i]) begin
              st  <= WAIT1;
              cnt <= LOAD;
            end
          end
          WAIT1: begin
            if (!s[i]) begin
              st <= ZERO;
            end else if (cnt == '0) begin
              st   <= ONE;
              tick <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ONE: begin
            if (!s[i]) begin
              st  <= WAIT0;
              cnt <= LOAD;
            end
          end
          WAIT0: begin
            if (s[i]) begin
              st <= ONE;
            end else if (cnt == '0) begin
              st <= ZERO;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        endcase
      end
    end

    // Level comes straight from the state register, so it cannot glitch.
    assign btnm[i]     = (st == ONE) || (st == WAIT0);
    assign btn_tick[i] = tick;
  end

endmodule

// File: tb/tb_pong_btn_debounce.sv
// Directed bench for pong_btn_debounce with DB_CYCLES=4.
// Edge 1 is the first rising edge sampling a new input value.
module tb_pong_btn_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_raw = 4'h0;
  logic [3:0] btnm;
  logic [3:0] btn_tick;
  logic [3:0] raw_al = 4'hF;
  logic [3:0] btnm_al;
  logic [3:0] tick_al;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pong_btn_debounce #(
    .N_BTN(4), .DB_CYCLES(4), .CNT_W(4), .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btnm(btnm), .btn_tick(btn_tick)
  );

  pong_btn_debounce #(
    .N_BTN(4), .DB_CYCLES(4), .CNT_W(4), .BTN_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw_al),
    .btnm(btnm_al), .btn_tick(tick_al)
  );

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // n cycles; btnm switches from mb to ma at edge e, tick = te only there.
  task automatic watch(input string tag, input int n, input logic [3:0] mb,
                       input logic [3:0] ma, input int e,
                       input logic [3:0] te);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check({tag, "_m"}, btnm, (e != 0 && i >= e) ? ma : mb);
      check({tag, "_t"}, btn_tick, (i == e) ? te : 4'h0);
    end
  endtask

  initial begin
    // 1: reset with all buttons held
    btn_raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_m", btnm, 4'h0);
      check("rst_t", btn_tick, 4'h0);
    end
    rst = 1'b1;
    watch("rel", 10, 4'h0, 4'hF, 7, 4'hF);
    check("al_idle", btnm_al, 4'h0);
    btn_raw = 4'h0;
    watch("rel_off", 10, 4'hF, 4'h0, 7, 4'h0);

    // 2: clean press and release on bit 2
    btn_raw = 4'h4;
    watch("press2", 20, 4'h0, 4'h4, 7, 4'h4);
    btn_raw = 4'h0;
    watch("drop2", 20, 4'h4, 4'h0, 7, 4'h0);

    // 3: bounce rejection, high runs of 3 on bit 0
    for (int i = 0; i < 40; i++) begin
      btn_raw = (i % 4 == 3) ? 4'h0 : 4'h1;
      @(negedge clk);
      check("bnc_m", btnm, 4'h0);
      check("bnc_t", btn_tick, 4'h0);
    end
    btn_raw = 4'h0;
    watch("bnc_end", 10, 4'h0, 4'h0, 0, 4'h0);

    // 4: release bounce on bit 1
    btn_raw = 4'h2;
    watch("press1", 10, 4'h0, 4'h2, 7, 4'h2);
    btn_raw = 4'h0;
    watch("rb_lo", 2, 4'h2, 4'h2, 0, 4'h0);
    btn_raw = 4'h2;
    watch("rb_hi", 12, 4'h2, 4'h2, 0, 4'h0);
    btn_raw = 4'h0;
    watch("drop1", 10, 4'h2, 4'h0, 7, 4'h0);

    // 5: staggered presses on bits 3 and 0
    btn_raw = 4'h8;
    for (int i = 1; i <= 14; i++) begin
      logic [3:0] em;
      logic [3:0] et;
      @(negedge clk);
      em = {i >= 7, 2'b00, i >= 9};
      et = {i == 7, 2'b00, i == 9};
      check("stag_m", btnm, em);
      check("stag_t", btn_tick, et);
      if (i == 2) btn_raw = 4'h9;
    end
    btn_raw = 4'h0;
    watch("stag_off", 10, 4'h9, 4'h0, 7, 4'h0);
    btn_raw = 4'h9;
    watch("sim", 10, 4'h0, 4'h9, 7, 4'h9);
    btn_raw = 4'h0;
    watch("sim_off", 10, 4'h9, 4'h0, 7, 4'h0);

    // 6: reset while bit 1 is mid-hold, bit 3 already pressed
    btn_raw = 4'h8;
    watch("pre3", 10, 4'h0, 4'h8, 7, 4'h8);
    btn_raw = 4'hA;
    watch("hold1", 4, 4'h8, 4'h8, 0, 4'h0);
    #2 rst = 1'b0;
    #1 check("arst_m", btnm, 4'h0);
    check("arst_t", btn_tick, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("arst_hold", btnm, 4'h0);
    rst = 1'b1;
    watch("after", 10, 4'h0, 4'hA, 7, 4'hA);
    btn_raw = 4'h0;
    watch("after_off", 10, 4'hA, 4'h0, 7, 4'h0);

    // 7: active-low instance
    check("al_f", btnm_al, 4'h0);
    raw_al = 4'hE;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("al_m", btnm_al, (i >= 7) ? 4'h1 : 4'h0);
      check("al_t", tick_al, (i == 7) ? 4'h1 : 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
